// File: rtl/seq_divider32.sv
// ============================================================================
// Module      : seq_divider32
// Description : Iterative unsigned restoring divider, one quotient bit per
//               clock, driven through a start/busy/done handshake.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] q_reg;     // starts as dividend, bits replaced by quotient bits
    logic [WIDTH-1:0] rem_reg;   // partial remainder
    logic [WIDTH-1:0] dvsr_reg;  // captured divisor
    logic [CW-1:0]    cnt;       // index of the bit resolved on the next RUN edge

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] q_upd;
    logic [WIDTH-1:0] rem_upd;
    logic             accept;

    // A new operation may be taken whenever no division is in flight,
    // which includes the DONE cycle (back-to-back issue).
    assign accept = start && (state != S_RUN);
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    // One restoring step: shift in the next dividend bit, trial-subtract,
    // keep the difference only when it did not borrow.
    always_comb begin
        r_shift = {rem_reg, q_reg[cnt]};
        trial   = r_shift - {1'b0, dvsr_reg};
        q_bit   = ~trial[WIDTH];
        q_upd   = q_reg;
        q_upd[cnt] = q_bit;
        rem_upd = q_bit ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    end

    // Control FSM plus datapath registers; results are published only
    // on the transition into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            q_reg       <= '0;
            rem_reg     <= '0;
            dvsr_reg    <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q_reg    <= dividend;
            rem_reg  <= '0;
            dvsr_reg <= divisor;
            cnt      <= CW'(WIDTH - 1);
            if (divisor == '0) begin
                // Nothing to iterate: report the conventional divide-by-zero result.
                state       <= S_DONE;
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                state       <= S_RUN;
                quotient    <= '0;
                remainder   <= '0;
                div_by_zero <= 1'b0;
            end
        end else begin
            case (state)
                S_RUN: begin
                    q_reg   <= q_upd;
                    rem_reg <= rem_upd;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= S_DONE;
                        quotient  <= q_upd;
                        remainder <= rem_upd;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
